// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type function codes and the canonical NOP.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LH    = 6'h21,
    OP_LW    = 6'h23,
    OP_SB    = 6'h28,
    OP_SH    = 6'h29,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam logic [5:0]  FN_JR     = 6'h08;
  localparam logic [5:0]  FN_JALR   = 6'h09;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage signal bundle: fetch inputs, hazard/writeback inputs and ID/EX outputs.
interface instruction_decode_if #(
  parameter int SIZE     = 32,
  parameter int REG_ADDR = 5
);
  logic [SIZE-1:0]     i_instruction;
  logic [SIZE-1:0]     i_pc_plus1;
  logic                i_ex_mem_read;
  logic                i_ex_reg_write;
  logic [REG_ADDR-1:0] i_ex_dest;
  logic                i_mem_reg_write;
  logic [REG_ADDR-1:0] i_mem_dest;
  logic                i_wb_we;
  logic [REG_ADDR-1:0] i_wb_addr;
  logic [SIZE-1:0]     i_wb_data;

  logic                o_stall;
  logic                o_jump;
  logic [SIZE-1:0]     o_jump_addr;
  logic [SIZE-1:0]     o_rs_data;
  logic [SIZE-1:0]     o_rt_data;
  logic [SIZE-1:0]     o_imm;
  logic [REG_ADDR-1:0] o_rs;
  logic [REG_ADDR-1:0] o_rt;
  logic [REG_ADDR-1:0] o_rd;
  logic [5:0]          o_opcode;
  logic [5:0]          o_funct;
  logic [4:0]          o_shamt;
  logic [SIZE-1:0]     o_pc_plus1;
  logic                o_valid;

  modport master (
    output i_instruction, i_pc_plus1, i_ex_mem_read, i_ex_reg_write, i_ex_dest,
           i_mem_reg_write, i_mem_dest, i_wb_we, i_wb_addr, i_wb_data,
    input  o_stall, o_jump, o_jump_addr, o_rs_data, o_rt_data, o_imm, o_rs, o_rt,
           o_rd, o_opcode, o_funct, o_shamt, o_pc_plus1, o_valid
  );

  modport slave (
    input  i_instruction, i_pc_plus1, i_ex_mem_read, i_ex_reg_write, i_ex_dest,
           i_mem_reg_write, i_mem_dest, i_wb_we, i_wb_addr, i_wb_data,
    output o_stall, o_jump, o_jump_addr, o_rs_data, o_rt_data, o_imm, o_rs, o_rt,
           o_rd, o_opcode, o_funct, o_shamt, o_pc_plus1, o_valid
  );

endinterface

// File: rtl/register_file.sv
// 2-read/1-write register file, R0 hardwired to zero.
// ID_REGFILE_BYPASS_EN: reads of the register being written return the write data.
module register_file #(
  parameter int SIZE      = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ADDR-1:0] rd_addr_a,
  output logic [SIZE-1:0]     rd_data_a,
  input  logic [REG_ADDR-1:0] rd_addr_b,
  output logic [SIZE-1:0]     rd_data_b,
  input  logic                we,
  input  logic [REG_ADDR-1:0] wr_addr,
  input  logic [SIZE-1:0]     wr_data
);

  logic [SIZE-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
`ifdef ID_REGFILE_BYPASS_EN
    if (we && rd_addr_a == wr_addr) rd_data_a = wr_data;
    if (we && rd_addr_b == wr_addr) rd_data_b = wr_data;
`endif
    // Zero check last so a bypass can never leak a value into R0.
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: IF/ID latch, register file, hazard detection, jump/branch resolution, ID/EX register.
// ID_REGFILE_BYPASS_EN enables register-file write-through (see register_file).
module instruction_decode
  import mips_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_ADDR  = 5
) (
  input logic                 clk,
  input logic                 rst,
  instruction_decode_if.slave bus
);

  logic [SIZE-1:0]     if_instr;
  logic [SIZE-1:0]     if_pc;
  opcode_e             op;
  logic [5:0]          funct;
  logic [4:0]          shamt;
  logic [REG_ADDR-1:0] rs, rt, rd;
  logic [15:0]         imm16;
  logic [SIZE-1:0]     imm_sext, imm_ext, branch_target;
  logic [SIZE-1:0]     rs_data, rt_data;
  logic                rs_used, rt_used, is_jr, is_branch_class;
  logic                ex_match, mem_match, load_use, branch_haz, stall;
  logic                jump;
  logic [SIZE-1:0]     jump_addr;

  assign op    = opcode_e'(if_instr[31:26]);
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd    = if_instr[15:11];
  assign shamt = if_instr[10:6];
  assign funct = if_instr[5:0];
  assign imm16 = if_instr[15:0];

  register_file #(
    .SIZE      (SIZE),
    .REG_COUNT (REG_COUNT),
    .REG_ADDR  (REG_ADDR)
  ) u_register_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rs),
    .rd_data_a (rs_data),
    .rd_addr_b (rt),
    .rd_data_b (rt_data),
    .we        (bus.i_wb_we),
    .wr_addr   (bus.i_wb_addr),
    .wr_data   (bus.i_wb_data)
  );

  assign imm_sext      = {{(SIZE-16){imm16[15]}}, imm16};
  assign imm_ext       = (op inside {OP_ANDI, OP_ORI, OP_XORI}) ? SIZE'(imm16) : imm_sext;
  assign branch_target = if_pc + imm_sext;

  assign rs_used         = !(op inside {OP_J, OP_JAL});
  assign rt_used         = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  assign is_jr           = (op == OP_RTYPE) && (funct == FN_JR || funct == FN_JALR);
  assign is_branch_class = (op inside {OP_BEQ, OP_BNE}) || is_jr;

  assign ex_match  = (bus.i_ex_dest != '0) &&
                     ((rs_used && bus.i_ex_dest == rs) || (rt_used && bus.i_ex_dest == rt));
  assign mem_match = (bus.i_mem_dest != '0) &&
                     ((rs_used && bus.i_mem_dest == rs) || (rt_used && bus.i_mem_dest == rt));

  assign load_use   = bus.i_ex_mem_read && ex_match;
  // Branches compare in ID, so any in-flight producer of an operand must reach WB first.
  assign branch_haz = is_branch_class &&
                      ((bus.i_ex_reg_write && ex_match) || (bus.i_mem_reg_write && mem_match));
  assign stall      = load_use || branch_haz;

  always_comb begin
    jump      = 1'b0;
    jump_addr = '0;
    if (!stall) begin
      case (op)
        OP_J, OP_JAL: begin
          jump      = 1'b1;
          jump_addr = SIZE'(if_instr[25:0]);
        end
        OP_BEQ: if (rs_data == rt_data) begin
          jump      = 1'b1;
          jump_addr = branch_target;
        end
        OP_BNE: if (rs_data != rt_data) begin
          jump      = 1'b1;
          jump_addr = branch_target;
        end
        OP_RTYPE: if (is_jr) begin
          jump      = 1'b1;
          jump_addr = rs_data;
        end
        default: ;
      endcase
    end
  end

  // IF/ID: jump takes priority over load (it is already masked by stall).
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instr <= SIZE'(NOP_INSTR);
      if_pc    <= '0;
    end else if (jump) begin
      if_instr <= SIZE'(NOP_INSTR);
      if_pc    <= '0;
    end else if (!stall) begin
      if_instr <= bus.i_instruction;
      if_pc    <= bus.i_pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stall) begin
      bus.o_rs_data  <= '0;
      bus.o_rt_data  <= '0;
      bus.o_imm      <= '0;
      bus.o_rs       <= '0;
      bus.o_rt       <= '0;
      bus.o_rd       <= '0;
      bus.o_opcode   <= '0;
      bus.o_funct    <= '0;
      bus.o_shamt    <= '0;
      bus.o_pc_plus1 <= '0;
      bus.o_valid    <= 1'b0;
    end else begin
      bus.o_rs_data  <= rs_data;
      bus.o_rt_data  <= rt_data;
      bus.o_imm      <= imm_ext;
      bus.o_rs       <= rs;
      bus.o_rt       <= rt;
      bus.o_rd       <= (op == OP_JAL) ? REG_ADDR'(31) : rd;
      bus.o_opcode   <= if_instr[31:26];
      bus.o_funct    <= funct;
      bus.o_shamt    <= shamt;
      bus.o_pc_plus1 <= if_pc;
      bus.o_valid    <= (if_instr != SIZE'(NOP_INSTR));
    end
  end

  assign bus.o_stall     = stall;
  assign bus.o_jump      = jump;
  assign bus.o_jump_addr = jump_addr;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: reset, operand read, load-use, branches, jumps, hazards.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ADDU_7_5_3 = 32'h00A3_3821;
  localparam logic [31:0] ORI_4_1    = 32'h3424_8001;
  localparam logic [31:0] ADDIU_4_1  = 32'h2424_8001;
  localparam logic [31:0] BEQ_1_1_M2 = 32'h1021_FFFE;
  localparam logic [31:0] J_3        = 32'h0800_0003;
  localparam logic [31:0] JAL_3      = 32'h0C00_0003;
  localparam logic [31:0] BNE_2_0_4  = 32'h1440_0004;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    cyc();
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.i_instruction   = '0;
    bus.i_pc_plus1      = '0;
    bus.i_ex_mem_read   = 1'b0;
    bus.i_ex_reg_write  = 1'b0;
    bus.i_ex_dest       = '0;
    bus.i_mem_reg_write = 1'b0;
    bus.i_mem_dest      = '0;
    bus.i_wb_we         = 1'b0;
    bus.i_wb_addr       = '0;
    bus.i_wb_data       = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_stall", 32'(bus.o_stall), 32'd0);
    check("rst_jump", 32'(bus.o_jump), 32'd0);
    check("rst_jump_addr", bus.o_jump_addr, 32'd0);
    check("rst_rd", 32'(bus.o_rd), 32'd0);
    check("rst_pc_plus1", bus.o_pc_plus1, 32'd0);

    cyc();
    #1;
    check("nop_valid", 32'(bus.o_valid), 32'd0);
    check("nop_imm", bus.o_imm, 32'd0);

    wb_write(5'd1, 32'h0000_0055);
    wb_write(5'd3, 32'h0000_0003);
    wb_write(5'd0, 32'h0000_DEAD);
    // R5 written at the same edge that ADDU enters IF/ID
    bus.i_instruction = ADDU_7_5_3;
    wb_write(5'd5, 32'h0000_0010);
    bus.i_instruction = '0;
    #1;
    check("addu_ifid_valid", 32'(bus.o_valid), 32'd0);
    cyc();
    check("addu_valid", 32'(bus.o_valid), 32'd1);
    check("addu_rd", 32'(bus.o_rd), 32'd7);
    check("addu_rt_data", bus.o_rt_data, 32'h3);
    check("addu_rs_data", bus.o_rs_data, 32'h10);
    check("addu_funct", 32'(bus.o_funct), 32'h21);

    // Load-use: one bubble, then ADDU issues from the held IF/ID
    bus.i_instruction = ADDU_7_5_3;
    cyc();
    bus.i_instruction = '0;
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_dest     = 5'd5;
    #1;
    check("lu_stall", 32'(bus.o_stall), 32'd1);
    check("lu_jump", 32'(bus.o_jump), 32'd0);
    cyc();
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_dest     = '0;
    #1;
    check("lu_bubble_valid", 32'(bus.o_valid), 32'd0);
    check("lu_bubble_rd", 32'(bus.o_rd), 32'd0);
    check("lu_stall_clear", 32'(bus.o_stall), 32'd0);
    cyc();
    check("lu_issue_valid", 32'(bus.o_valid), 32'd1);
    check("lu_issue_rd", 32'(bus.o_rd), 32'd7);
    check("lu_issue_rs", 32'(bus.o_rs), 32'd5);

    // ORI: rt is a destination, not a source; immediate zero-extended
    bus.i_instruction = ORI_4_1;
    cyc();
    bus.i_instruction = '0;
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_dest     = 5'd4;
    #1;
    check("ori_no_stall", 32'(bus.o_stall), 32'd0);
    cyc();
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_dest     = '0;
    check("ori_imm", bus.o_imm, 32'h0000_8001);
    check("ori_opcode", 32'(bus.o_opcode), 32'h0D);
    check("ori_rt", 32'(bus.o_rt), 32'd4);
    bus.i_instruction = ADDIU_4_1;
    cyc();
    bus.i_instruction = '0;
    cyc();
    check("addiu_imm", bus.o_imm, 32'hFFFF_8001);

    // BEQ R1,R1,-2 at pc+1 = 10 -> target 8, following fetch squashed
    bus.i_instruction = BEQ_1_1_M2;
    bus.i_pc_plus1    = 32'd10;
    cyc();
    bus.i_instruction = ADDU_7_5_3;
    bus.i_pc_plus1    = 32'd11;
    #1;
    check("beq_jump", 32'(bus.o_jump), 32'd1);
    check("beq_target", bus.o_jump_addr, 32'd8);
    check("beq_stall", 32'(bus.o_stall), 32'd0);
    cyc();
    bus.i_instruction = '0;
    bus.i_pc_plus1    = '0;
    #1;
    check("beq_after_jump", 32'(bus.o_jump), 32'd0);
    check("beq_opcode", 32'(bus.o_opcode), 32'd4);
    check("beq_imm", bus.o_imm, 32'hFFFF_FFFE);
    check("beq_pc_plus1", bus.o_pc_plus1, 32'd10);
    cyc();
    check("beq_squash_valid", 32'(bus.o_valid), 32'd0);

    // J then JAL (JAL presented while J's flush is in IF/ID)
    bus.i_instruction = J_3;
    cyc();
    bus.i_instruction = JAL_3;
    #1;
    check("j_jump", 32'(bus.o_jump), 32'd1);
    check("j_target", bus.o_jump_addr, 32'd3);
    cyc();
    check("j_opcode", 32'(bus.o_opcode), 32'd2);
    cyc();
    bus.i_instruction = '0;
    #1;
    check("jal_jump", 32'(bus.o_jump), 32'd1);
    check("jal_target", bus.o_jump_addr, 32'd3);
    cyc();
    check("jal_rd", 32'(bus.o_rd), 32'd31);
    check("jal_opcode", 32'(bus.o_opcode), 32'd3);

    // BNE R2,R0 with a producer of R2 in EX, then MEM, then WB
    bus.i_instruction = BNE_2_0_4;
    bus.i_pc_plus1    = 32'd20;
    cyc();
    bus.i_instruction  = '0;
    bus.i_pc_plus1     = '0;
    bus.i_ex_reg_write = 1'b1;
    bus.i_ex_dest      = 5'd2;
    #1;
    check("bne_ex_stall", 32'(bus.o_stall), 32'd1);
    check("bne_ex_jump", 32'(bus.o_jump), 32'd0);
    check("bne_ex_addr", bus.o_jump_addr, 32'd0);
    cyc();
    bus.i_ex_reg_write  = 1'b0;
    bus.i_ex_dest       = '0;
    bus.i_mem_reg_write = 1'b1;
    bus.i_mem_dest      = 5'd2;
    #1;
    check("bne_ex_bubble", 32'(bus.o_valid), 32'd0);
    check("bne_mem_stall", 32'(bus.o_stall), 32'd1);
    cyc();
    bus.i_mem_reg_write = 1'b0;
    bus.i_mem_dest      = '0;
    bus.i_wb_we         = 1'b1;
    bus.i_wb_addr       = 5'd2;
    bus.i_wb_data       = 32'd5;
    #1;
    check("bne_mem_bubble", 32'(bus.o_valid), 32'd0);
    check("bne_wb_stall", 32'(bus.o_stall), 32'd0);
`ifdef ID_REGFILE_BYPASS_EN
    check("bne_wb_jump", 32'(bus.o_jump), 32'd1);
    check("bne_wb_target", bus.o_jump_addr, 32'd24);
`else
    check("bne_wb_jump", 32'(bus.o_jump), 32'd0);
    check("bne_wb_target", bus.o_jump_addr, 32'd0);
`endif
    cyc();
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    check("bne_issue_valid", 32'(bus.o_valid), 32'd1);
    check("bne_issue_opcode", 32'(bus.o_opcode), 32'd5);
    check("r0_write_ignored", bus.o_rt_data, 32'd0);
    bus.i_instruction = BNE_2_0_4;
    bus.i_pc_plus1    = 32'd20;
    cyc();
    bus.i_instruction = '0;
    bus.i_pc_plus1    = '0;
    #1;
    check("bne_taken_jump", 32'(bus.o_jump), 32'd1);
    check("bne_taken_target", bus.o_jump_addr, 32'd24);
    cyc();

    // Reset during a load-use stall clears everything, register file included
    bus.i_instruction = ADDU_7_5_3;
    cyc();
    bus.i_instruction = '0;
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_dest     = 5'd5;
    #1;
    check("rst_mid_stall_pre", 32'(bus.o_stall), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("rst_mid_stall", 32'(bus.o_stall), 32'd0);
    check("rst_mid_valid", 32'(bus.o_valid), 32'd0);
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_dest     = '0;
    bus.i_instruction = ADDU_7_5_3;
    cyc();
    bus.i_instruction = '0;
    cyc();
    check("rst_regs_valid", 32'(bus.o_valid), 32'd1);
    check("rst_regs_r3", bus.o_rt_data, 32'd0);
    check("rst_regs_r5", bus.o_rs_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
